// File: rtl/param_decoder_scan_pkg.sv
// Shared types and constants for the one-cold decoder / scanner.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned SEL_W_MIN = 2;
    localparam int unsigned SEL_W_MAX = 6;

endpackage

// File: rtl/param_decoder_scan_if.sv
// Control and output bundle of param_decoder_scan.
interface param_decoder_scan_if #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
);
    logic                  en_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [DWELL_W-1:0]    dwell;
    logic                  start;
    logic                  stop;
    logic [2**SEL_W-1:0]   y_n;
    logic [SEL_W-1:0]      idx;
    logic                  busy;
    logic                  wrap;

    modport master (
        output en_n, mode, sel, dwell, start, stop,
        input  y_n, idx, busy, wrap
    );

    modport slave (
        input  en_n, mode, sel, dwell, start, stop,
        output y_n, idx, busy, wrap
    );
endinterface

// File: rtl/param_decoder_scan_dec.sv
// Combinational SEL_W-to-N active-low one-cold decoder with active-low enable.
module onecold_dec #(
    parameter int SEL_W = 5
) (
    input  logic                en_n_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [2**SEL_W-1:0] y_n_o
);
    always_comb begin
        y_n_o = '1;
        if (!en_n_i) begin
            y_n_o[sel_i] = 1'b0;
        end
    end
endmodule

// File: rtl/param_decoder_scan.sv
// Registered one-cold decoder with optional auto-scan (macro DECODER_SCAN_EN).
// Default build: direct decode only, busy/wrap tied low.
module param_decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    param_decoder_scan_if.slave bus
);
    localparam int N = 2**SEL_W;

    if (SEL_W < int'(SEL_W_MIN) || SEL_W > int'(SEL_W_MAX)) begin : g_bad_sel_w
        $error("param_decoder_scan: SEL_W out of legal range");
    end

    logic [N-1:0]     y_n_q, y_n_d, dec_y_n;
    logic [SEL_W-1:0] idx_q, idx_d, dec_sel;
    logic             dec_en_n;

    onecold_dec #(.SEL_W(SEL_W)) u_dec (
        .en_n_i (dec_en_n),
        .sel_i  (dec_sel),
        .y_n_o  (dec_y_n)
    );

    assign y_n_d   = dec_y_n;
    assign bus.y_n = y_n_q;
    assign bus.idx = idx_q;

`ifdef DECODER_SCAN_EN
    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_n_q   <= '1;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_n_q   <= y_n_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        dec_en_n = 1'b1;
        dec_sel  = idx_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.en_n) begin
                    if (bus.mode == MODE_DIRECT) begin
                        idx_d    = bus.sel;
                        dec_en_n = 1'b0;
                        dec_sel  = bus.sel;
                    end else if (bus.start && !bus.stop) begin
                        state_d  = SCAN;
                        idx_d    = bus.sel;
                        cnt_d    = bus.dwell;
                        dec_en_n = 1'b0;
                        dec_sel  = bus.sel;
                    end
                end
            end
            SCAN: begin
                if (bus.stop || bus.en_n) begin
                    state_d = IDLE;
                end else begin
                    dec_en_n = 1'b0;
                    if (cnt_q == '0) begin
                        // Wrap flag is registered alongside the new index so both change on the same edge.
                        idx_d   = idx_q + SEL_W'(1);
                        dec_sel = idx_q + SEL_W'(1);
                        cnt_d   = bus.dwell;
                        wrap_d  = (idx_q == '1);
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == SCAN);
    assign bus.wrap = wrap_q;
`else
    logic unused_scan_inputs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_n_q <= '1;
            idx_q <= '0;
        end else begin
            y_n_q <= y_n_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        dec_en_n = bus.en_n;
        dec_sel  = bus.sel;
        idx_d    = bus.en_n ? idx_q : bus.sel;
    end

    assign unused_scan_inputs = ^{bus.mode, bus.start, bus.stop, bus.dwell};
    assign bus.busy = 1'b0;
    assign bus.wrap = 1'b0;
`endif
endmodule

// File: tb/tb_param_decoder_scan.sv
// Scoreboard bench for param_decoder_scan; scan scenarios when DECODER_SCAN_EN is defined.
module tb_param_decoder_scan;
    localparam int SEL_W   = 5;
    localparam int DWELL_W = 8;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    typedef struct {
        int unsigned cyc;
        logic [31:0] y;
        logic [4:0]  idx;
        logic        busy;
        logic        wrap;
        string       nm;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_fail;
    exp_t        sb[$];

    param_decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    param_decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_now(input string nm, input logic [31:0] ey, input logic [4:0] ei,
                             input logic eb, input logic ew);
        check({nm, ".y_n"},  64'(bus.y_n),  64'(ey));
        check({nm, ".idx"},  64'(bus.idx),  64'(ei));
        check({nm, ".busy"}, 64'(bus.busy), 64'(eb));
        check({nm, ".wrap"}, 64'(bus.wrap), 64'(ew));
    endtask

    // Monitor: one-cold property every cycle, plus scoreboard entries due this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("onecold", 64'($countones(~bus.y_n) <= 1), 64'd1);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                check({e.nm, ".missed"}, 64'(e.cyc), 64'(cyc));
            end else begin
                check_now(e.nm, e.y, e.idx, e.busy, e.wrap);
            end
        end
    end

    task automatic drive(input logic en_n, input logic mode, input logic [4:0] sel,
                         input logic [7:0] dwell, input logic start, input logic stop,
                         input logic [31:0] ey, input logic [4:0] ei, input logic eb,
                         input logic ew, input string nm);
        exp_t e;
        @(negedge clk);
        bus.en_n  = en_n;
        bus.mode  = mode;
        bus.sel   = sel;
        bus.dwell = dwell;
        bus.start = start;
        bus.stop  = stop;
        e.cyc  = cyc + 1;
        e.y    = ey;
        e.idx  = ei;
        e.busy = eb;
        e.wrap = ew;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        int unsigned budget;
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic async_reset_check(input string nm);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_now(nm, ONES, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cyc    = 0;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.en_n = 1'b1; bus.mode = 1'b0; bus.sel = '0; bus.dwell = '0;
        bus.start = 1'b0; bus.stop = 1'b0;
        #2 check_now("reset", ONES, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Direct decode and disable
        drive(0, 0, 5'd19, 8'd0, 0, 0, 32'hFFF7_FFFF, 5'd19, 0, 0, "direct19");
        drive(1, 0, 5'd19, 8'd0, 0, 0, ONES,          5'd19, 0, 0, "disable");
        drive(0, 0, 5'd0,  8'd0, 0, 0, 32'hFFFF_FFFE, 5'd0,  0, 0, "direct0");
        drive(0, 0, 5'd31, 8'd0, 0, 0, 32'h7FFF_FFFF, 5'd31, 0, 0, "direct31");

`ifdef DECODER_SCAN_EN
        // Scan from 30 with dwell 2 through the wrap; sel/mode changes and a second start are ignored
        drive(0, 1, 5'd30, 8'd2, 1, 0, 32'hBFFF_FFFF, 5'd30, 1, 0, "scan30a");
        drive(0, 0, 5'd5,  8'd2, 0, 0, 32'hBFFF_FFFF, 5'd30, 1, 0, "scan30b");
        drive(0, 0, 5'd5,  8'd2, 1, 0, 32'hBFFF_FFFF, 5'd30, 1, 0, "scan30c");
        drive(0, 0, 5'd5,  8'd2, 0, 0, 32'h7FFF_FFFF, 5'd31, 1, 0, "scan31a");
        drive(0, 0, 5'd5,  8'd2, 0, 0, 32'h7FFF_FFFF, 5'd31, 1, 0, "scan31b");
        drive(0, 0, 5'd5,  8'd2, 0, 0, 32'h7FFF_FFFF, 5'd31, 1, 0, "scan31c");
        drive(0, 0, 5'd5,  8'd2, 0, 0, 32'hFFFF_FFFE, 5'd0,  1, 1, "scanwrap");
        drive(0, 0, 5'd5,  8'd2, 0, 0, 32'hFFFF_FFFE, 5'd0,  1, 0, "scan0b");
        drive(0, 1, 5'd5,  8'd2, 0, 1, ONES,          5'd0,  0, 0, "stop");
        drive(0, 1, 5'd9,  8'd2, 1, 1, ONES,          5'd0,  0, 0, "start_and_stop");
        drive(0, 1, 5'd9,  8'd2, 0, 0, ONES,          5'd0,  0, 0, "idle_scanmode");

        // dwell 0 scan from 5, aborted by en_n at idx 7
        drive(0, 1, 5'd5, 8'd0, 1, 0, 32'hFFFF_FFDF, 5'd5, 1, 0, "d0_5");
        drive(0, 1, 5'd5, 8'd0, 0, 0, 32'hFFFF_FFBF, 5'd6, 1, 0, "d0_6");
        drive(0, 1, 5'd5, 8'd0, 0, 0, 32'hFFFF_FF7F, 5'd7, 1, 0, "d0_7");
        drive(1, 1, 5'd5, 8'd0, 0, 0, ONES,          5'd7, 0, 0, "abort_en_n");

        // dwell 0 wrap 31 -> 0 -> 1
        drive(0, 1, 5'd31, 8'd0, 1, 0, 32'h7FFF_FFFF, 5'd31, 1, 0, "w_31");
        drive(0, 1, 5'd31, 8'd0, 0, 0, 32'hFFFF_FFFE, 5'd0,  1, 1, "w_0");
        drive(0, 1, 5'd31, 8'd0, 0, 0, 32'hFFFF_FFFD, 5'd1,  1, 0, "w_1");
        drive(0, 1, 5'd31, 8'd0, 0, 1, ONES,          5'd1,  0, 0, "w_stop");

        // Async reset mid-scan, then wait for a new start
        drive(0, 1, 5'd10, 8'd3, 1, 0, 32'hFFFF_FBFF, 5'd10, 1, 0, "r_10a");
        drive(0, 1, 5'd10, 8'd3, 0, 0, 32'hFFFF_FBFF, 5'd10, 1, 0, "r_10b");
        drain();
        async_reset_check("async_rst_scan");
        drive(0, 1, 5'd10, 8'd3, 0, 0, ONES, 5'd0, 0, 0, "post_rst_idle");
        drive(0, 1, 5'd3,  8'd0, 1, 0, 32'hFFFF_FFF7, 5'd3, 1, 0, "post_rst_start");
        drive(0, 1, 5'd3,  8'd0, 0, 1, ONES,          5'd3, 0, 0, "post_rst_stop");
`else
        // Scan controls have no effect: always direct decode
        drive(0, 1, 5'd12, 8'd2, 1, 0, 32'hFFFF_EFFF, 5'd12, 0, 0, "ns_start");
        drive(0, 1, 5'd12, 8'd2, 0, 0, 32'hFFFF_EFFF, 5'd12, 0, 0, "ns_hold");
        drive(0, 1, 5'd3,  8'd0, 1, 1, 32'hFFFF_FFF7, 5'd3,  0, 0, "ns_startstop");
        drive(1, 1, 5'd3,  8'd0, 0, 0, ONES,          5'd3,  0, 0, "ns_disable");
        drive(0, 0, 5'd9,  8'd0, 0, 0, 32'hFFFF_FDFF, 5'd9,  0, 0, "ns_9");
        drain();
        async_reset_check("async_rst_direct");
        drive(0, 1, 5'd2,  8'd0, 0, 0, 32'hFFFF_FFFB, 5'd2,  0, 0, "ns_post_rst");
`endif
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
